switch_allocator: RTL and testbench
===================================

SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 The module SHALL have parameter NPORTS, default 5, meaning the number of router ports; port index 0=L, 1=N, 2=E, 3=W, 4=S.
REQ-002 The module SHALL have parameter LEN_W, default 12, meaning the width of the packet-length field.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port req, input, NPORTS*NPORTS bits: bit [i*NPORTS+o] means input i's routing logic requests output o.
REQ-006 The module SHALL have port flit_id, input, NPORTS*3 bits: flit type at the head of each input FIFO.
REQ-007 The module SHALL have port length, input, NPORTS*LEN_W bits: packet length in flits, header included, taken from each input's header flit.
REQ-008 The module SHALL have port empty, input, NPORTS bits: input FIFO i is empty.
REQ-009 The module SHALL have port dcts, input, NPORTS bits: downstream of output o can accept a flit.
REQ-010 The module SHALL have port grant, output, NPORTS*NPORTS bits: bit [o*NPORTS+i] means a flit moves from input i to output o this cycle.
REQ-011 The module SHALL have port sel, output, NPORTS*NPORTS bits: one-hot crossbar select per output, equal to the locked owner; zero when idle.
REQ-012 The module SHALL have port rd_en, output, NPORTS bits: pop strobe for input FIFO i, equal to the OR of grant over all outputs.
REQ-013 The module SHALL have port busy, output, NPORTS bits: output o is locked to a packet.

Function
REQ-014 Each output SHALL run a two-state FSM: IDLE and LOCKED.
REQ-015 In IDLE, output o SHALL consider input i eligible only when all of these hold: req[i*NPORTS+o]=1, flit_id[i]=HEADER, empty[i]=0, and input i is not owned by any output.
REQ-016 In IDLE, output o SHALL select the first eligible input in round-robin order starting at ptr[o]+1, modulo NPORTS.
REQ-017 On selection, output o SHALL enter LOCKED at the next edge, register the owner, and load cnt = max(length[owner],1).
REQ-018 If two idle outputs select the same input in one cycle, the lower output index SHALL win; the other output stays IDLE.
REQ-019 In LOCKED, grant[o][owner] SHALL be combinational: asserted exactly when dcts[o]=1 and empty[owner]=0.
REQ-020 Each granted cycle SHALL decrement cnt by 1.
REQ-021 A grant with cnt=1 SHALL return the output to IDLE at the next edge and set ptr[o]=owner.
REQ-022 An output SHALL spend at least one cycle in IDLE between packets.
REQ-023 Latency: header presented in cycle t yields LOCKED in cycle t+1 and a first grant in cycle t+1 if dcts and ~empty allow.
REQ-024 dcts=0 or empty=1 in LOCKED SHALL stall the output: no grant, cnt held, lock held.
REQ-025 A non-HEADER flit at an unowned input SHALL be ignored: it receives no grant and is never popped by this block.
REQ-026 Each input SHALL be owned by at most one output at a time.
REQ-027 rd_en SHALL be one-hot or zero per input.

Reset
REQ-028 While rst=1, all FSMs SHALL be IDLE; grant, sel, rd_en and busy SHALL be 0; cnt SHALL be 0; ptr SHALL be NPORTS-1, so L is searched first.
REQ-029 Reset asserted mid-packet SHALL drop every lock immediately and asynchronously, without waiting for a clock edge.

Structure
REQ-030 A shared package SHALL hold the flit-type constants (HEADER=3'b001, BODY=3'b010, TAIL=3'b100), the port-index constants, and the FSM state encoding.
REQ-031 The per-output FSM, round-robin pointer and counter SHALL be a sub-module, sa_output_lock, instantiated NPORTS times.
REQ-032 The top level SHALL perform the cross-output ownership masking and the rd_en OR-reduction.

Verification
REQ-033 Scenario: L sends a header with length=4 toward E, dcts[E]=1 throughout -> busy[E] rises at t+1; grant[E][L] is high for 4 consecutive cycles; busy[E] falls the cycle after; ptr[E]=0.
REQ-034 Scenario: N, W and S headers toward L in the same cycle, each length=2 -> served in order N, W, S, each for 2 grants, each followed by an IDLE gap cycle.
REQ-035 Scenario: dcts[N] low for 3 cycles mid-packet (length=5, from E) -> no grant and cnt frozen during the stall; exactly 5 grants in total.
REQ-036 Scenario: length=0 header -> treated as 1; a single grant, then release.
REQ-037 Scenario: rst pulsed during the 2nd flit of a length=6 packet -> busy, grant and rd_en go to 0 before the next edge; after reset, L has first priority.
REQ-038 Scenario: a BODY flit with req set at an unowned input -> grant and rd_en stay 0 indefinitely.

Source files
------------

// File: rtl/switch_allocator_pkg.sv
// Shared constants for the switch allocator: flit types, port indices and the
// per-output lock state encoding.
package switch_allocator_pkg;

    localparam int unsigned FLIT_W = 3;

    localparam logic [FLIT_W-1:0] FLIT_HEADER = 3'b001;
    localparam logic [FLIT_W-1:0] FLIT_BODY   = 3'b010;
    localparam logic [FLIT_W-1:0] FLIT_TAIL   = 3'b100;

    localparam int unsigned PORT_L = 0;
    localparam int unsigned PORT_N = 1;
    localparam int unsigned PORT_E = 2;
    localparam int unsigned PORT_W = 3;
    localparam int unsigned PORT_S = 4;

    typedef enum logic {
        LOCK_IDLE = 1'b0,
        LOCK_BUSY = 1'b1
    } lock_state_e;

    function automatic logic is_header(input logic [FLIT_W-1:0] f);
        return f == FLIT_HEADER;
    endfunction

endpackage

// File: rtl/sa_output_lock.sv
// Per-output lock FSM: round-robin pick of a header, packet-length countdown,
// and release back to idle with the pointer parked on the last owner.
module sa_output_lock
    import switch_allocator_pkg::*;
#(
    parameter int unsigned NPORTS = 5,
    parameter int unsigned LEN_W  = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NPORTS-1:0]       elig,
    input  logic                    accept,
    input  logic                    dcts,
    input  logic [NPORTS-1:0]       empty,
    input  logic [NPORTS*LEN_W-1:0] length,
    output logic [NPORTS-1:0]       pick_c,
    output logic [NPORTS-1:0]       grant_c,
    output logic [NPORTS-1:0]       sel,
    output logic                    busy
);

    localparam int unsigned IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    lock_state_e      state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             fire;
    logic [LEN_W-1:0] len_arr [NPORTS];

    for (genvar i = 0; i < NPORTS; i++) begin : g_len
        assign len_arr[i] = length[i*LEN_W +: LEN_W];
    end

    // Round-robin search starting just after the last served input
    always_comb begin
        int unsigned idx;
        idx        = 0;
        pick_idx   = '0;
        pick_found = 1'b0;
        pick_c     = '0;
        for (int unsigned k = 1; k <= NPORTS; k++) begin
            idx = (32'(ptr_q) + k) % NPORTS;
            if (!pick_found && elig[IDX_W'(idx)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(idx);
            end
        end
        if (pick_found && (state_q == LOCK_IDLE)) begin
            pick_c[pick_idx] = 1'b1;
        end
    end

    assign busy    = (state_q == LOCK_BUSY);
    assign sel     = busy ? (NPORTS'(1) << owner_q) : '0;
    assign fire    = busy && dcts && !empty[owner_q];
    assign grant_c = fire ? sel : '0;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            LOCK_IDLE: begin
                if (accept && (pick_c != '0)) begin
                    state_d = LOCK_BUSY;
                    owner_d = pick_idx;
                    // A zero length field still carries the header flit itself
                    cnt_d   = (len_arr[pick_idx] == '0) ? LEN_W'(1) : len_arr[pick_idx];
                end
            end
            LOCK_BUSY: begin
                if (fire) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = LOCK_IDLE;
                        ptr_d   = owner_q;
                        owner_d = '0;
                    end
                end
            end
            default: state_d = LOCK_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOCK_IDLE;
            owner_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= IDX_W'(NPORTS - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Wormhole switch allocator: one lock FSM per output, with cross-output input
// ownership masking, same-cycle conflict resolution and FIFO pop generation.
module switch_allocator
    import switch_allocator_pkg::*;
#(
    parameter int unsigned NPORTS = 5,
    parameter int unsigned LEN_W  = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NPORTS*NPORTS-1:0]  req,
    input  logic [NPORTS*FLIT_W-1:0]  flit_id,
    input  logic [NPORTS*LEN_W-1:0]   length,
    input  logic [NPORTS-1:0]         empty,
    input  logic [NPORTS-1:0]         dcts,
    output logic [NPORTS*NPORTS-1:0]  grant,
    output logic [NPORTS*NPORTS-1:0]  sel,
    output logic [NPORTS-1:0]         rd_en,
    output logic [NPORTS-1:0]         busy
);

    logic [NPORTS-1:0] elig    [NPORTS];
    logic [NPORTS-1:0] pick    [NPORTS];
    logic [NPORTS-1:0] grant_o [NPORTS];
    logic [NPORTS-1:0] sel_o   [NPORTS];
    logic [NPORTS-1:0] owned;
    logic [NPORTS-1:0] taken;
    logic [NPORTS-1:0] accept;

    always_comb begin
        owned = '0;
        for (int unsigned o = 0; o < NPORTS; o++) begin
            owned = owned | sel_o[o];
        end
    end

    // Input i is a candidate for output o only with a fresh header and no owner
    always_comb begin
        for (int unsigned o = 0; o < NPORTS; o++) begin
            for (int unsigned i = 0; i < NPORTS; i++) begin
                elig[o][i] = req[i*NPORTS + o]
                           && is_header(flit_id[i*FLIT_W +: FLIT_W])
                           && !empty[i]
                           && !owned[i];
            end
        end
    end

    // Lower output index wins when two idle outputs pick the same input
    always_comb begin
        taken  = '0;
        accept = '0;
        for (int unsigned o = 0; o < NPORTS; o++) begin
            accept[o] = (pick[o] != '0) && ((pick[o] & taken) == '0);
            taken     = taken | pick[o];
        end
    end

    for (genvar o = 0; o < NPORTS; o++) begin : g_out
        sa_output_lock #(
            .NPORTS (NPORTS),
            .LEN_W  (LEN_W)
        ) u_lock (
            .clk     (clk),
            .rst     (rst),
            .elig    (elig[o]),
            .accept  (accept[o]),
            .dcts    (dcts[o]),
            .empty   (empty),
            .length  (length),
            .pick_c  (pick[o]),
            .grant_c (grant_o[o]),
            .sel     (sel_o[o]),
            .busy    (busy[o])
        );
    end

    always_comb begin
        grant = '0;
        sel   = '0;
        rd_en = '0;
        for (int unsigned o = 0; o < NPORTS; o++) begin
            grant[o*NPORTS +: NPORTS] = grant_o[o];
            sel[o*NPORTS +: NPORTS]   = sel_o[o];
            rd_en                     = rd_en | grant_o[o];
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator with a cycle-level packet model and
// hand-computed scenario checks.
module tb_switch_allocator;
    import switch_allocator_pkg::*;

    localparam int NP = 5;
    localparam int LW = 12;

    logic              clk;
    logic              rst;
    logic [NP*NP-1:0]  req;
    logic [NP*3-1:0]   flit_id;
    logic [NP*LW-1:0]  length;
    logic [NP-1:0]     empty;
    logic [NP-1:0]     dcts;
    logic [NP*NP-1:0]  grant;
    logic [NP*NP-1:0]  sel;
    logic [NP-1:0]     rd_en;
    logic [NP-1:0]     busy;

    switch_allocator #(.NPORTS(NP), .LEN_W(LW)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .flit_id (flit_id),
        .length  (length),
        .empty   (empty),
        .dcts    (dcts),
        .grant   (grant),
        .sel     (sel),
        .rd_en   (rd_en),
        .busy    (busy)
    );

    int vectors     = 0;
    int miscompares = 0;

    int          m_own [NP];
    int          m_cnt [NP];
    int          m_ptr [NP];
    logic [NP-1:0] m_pop = '0;
    int          gcnt [NP][NP];

    int left  [NP];
    int plen  [NP];
    bit first [NP];
    bit force_body [NP];

    logic [4:0] s2_pat [9];
    logic       s3_pat [8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h want %0h", name, $time, got, want);
        end
    endtask

    // Packet-level reference: owner/remaining/pointer per output
    always @(negedge clk) begin : model
        logic [NP*NP-1:0] eg;
        logic [NP*NP-1:0] es;
        logic [NP-1:0]    er;
        logic [NP-1:0]    eb;
        int nown [NP];
        bit owned [NP];
        bit claimed [NP];
        bit found;
        int i;
        eg = '0; es = '0; er = '0; eb = '0;
        if (rst) begin
            for (int o = 0; o < NP; o++) begin
                m_own[o] = -1;
                m_cnt[o] = 0;
                m_ptr[o] = NP - 1;
            end
        end else begin
            for (int o = 0; o < NP; o++) begin
                if (m_own[o] >= 0) begin
                    eb[o] = 1'b1;
                    es[o*NP + m_own[o]] = 1'b1;
                    if (dcts[o] && !empty[m_own[o]]) begin
                        eg[o*NP + m_own[o]] = 1'b1;
                        er[m_own[o]] = 1'b1;
                    end
                end
            end
        end
        chk("grant", 64'(grant), 64'(eg));
        chk("sel",   64'(sel),   64'(es));
        chk("rd_en", 64'(rd_en), 64'(er));
        chk("busy",  64'(busy),  64'(eb));
        for (int o = 0; o < NP; o++)
            for (int n = 0; n < NP; n++)
                if (grant[o*NP + n]) gcnt[o][n]++;
        m_pop = er;
        if (!rst) begin
            for (int o = 0; o < NP; o++) begin
                nown[o] = m_own[o];
                owned[o] = 1'b0;
                claimed[o] = 1'b0;
            end
            for (int o = 0; o < NP; o++)
                if (m_own[o] >= 0) owned[m_own[o]] = 1'b1;
            for (int o = 0; o < NP; o++) begin
                if (m_own[o] >= 0 && eg[o*NP + m_own[o]]) begin
                    m_cnt[o]--;
                    if (m_cnt[o] == 0) begin
                        nown[o] = -1;
                        m_ptr[o] = m_own[o];
                    end
                end
            end
            for (int o = 0; o < NP; o++) begin
                if (m_own[o] < 0) begin
                    found = 1'b0;
                    for (int k = 1; k <= NP; k++) begin
                        i = (m_ptr[o] + k) % NP;
                        if (!found && req[i*NP + o] && flit_id[i*3 +: 3] == FLIT_HEADER
                            && !empty[i] && !owned[i]) begin
                            found = 1'b1;
                            if (!claimed[i]) begin
                                claimed[i] = 1'b1;
                                nown[o] = i;
                                m_cnt[o] = (length[i*LW +: LW] == '0) ? 1 : int'(length[i*LW +: LW]);
                            end
                        end
                    end
                end
            end
            for (int o = 0; o < NP; o++) m_own[o] = nown[o];
        end
    end

    task automatic drive_inputs();
        for (int i = 0; i < NP; i++) begin
            empty[i] = (left[i] == 0);
            if (force_body[i])      flit_id[i*3 +: 3] = FLIT_BODY;
            else if (first[i])      flit_id[i*3 +: 3] = FLIT_HEADER;
            else if (left[i] == 1)  flit_id[i*3 +: 3] = FLIT_TAIL;
            else                    flit_id[i*3 +: 3] = FLIT_BODY;
            length[i*LW +: LW] = LW'(plen[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (m_pop[i] && left[i] > 0) begin
                left[i]--;
                first[i] = 1'b0;
            end
        end
        drive_inputs();
    endtask

    task automatic send_pkt(input int i, input int o, input int lenf, input int nfl);
        req[i*NP + o] = 1'b1;
        left[i]  = nfl;
        first[i] = 1'b1;
        plen[i]  = lenf;
        drive_inputs();
    endtask

    task automatic clear_gcnt();
        for (int o = 0; o < NP; o++)
            for (int n = 0; n < NP; n++) gcnt[o][n] = 0;
    endtask

    initial begin
        int tot;
        s2_pat[0] = 5'b00010; s2_pat[1] = 5'b00010; s2_pat[2] = 5'b00000;
        s2_pat[3] = 5'b01000; s2_pat[4] = 5'b01000; s2_pat[5] = 5'b00000;
        s2_pat[6] = 5'b10000; s2_pat[7] = 5'b10000; s2_pat[8] = 5'b00000;
        s3_pat[0] = 1'b1; s3_pat[1] = 1'b1; s3_pat[2] = 1'b0; s3_pat[3] = 1'b0;
        s3_pat[4] = 1'b0; s3_pat[5] = 1'b1; s3_pat[6] = 1'b1; s3_pat[7] = 1'b1;

        rst  = 1'b1;
        req  = '0;
        dcts = '1;
        for (int i = 0; i < NP; i++) begin
            left[i] = 0; plen[i] = 0; first[i] = 1'b0; force_body[i] = 1'b0;
        end
        clear_gcnt();
        drive_inputs();

        tick(); #1;
        chk("rst_busy",  64'(busy),  64'd0);
        chk("rst_sel",   64'(sel),   64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_rd_en", 64'(rd_en), 64'd0);
        tick();
        rst = 1'b0;

        // L -> E, four flits
        tick(); clear_gcnt(); send_pkt(PORT_L, PORT_E, 4, 4);
        tick(); #1;
        chk("s1_busy_rise", 64'(busy[PORT_E]), 64'd1);
        for (int k = 0; k < 4; k++) begin
            if (k != 0) begin tick(); #1; end
            chk("s1_grant_E_L", 64'(grant[PORT_E*NP + PORT_L]), 64'd1);
        end
        tick(); #1;
        chk("s1_busy_fall", 64'(busy[PORT_E]), 64'd0);
        chk("s1_grant_cnt", 64'(gcnt[PORT_E][PORT_L]), 64'd4);
        send_pkt(PORT_L, PORT_E, 1, 1);
        send_pkt(PORT_N, PORT_E, 1, 1);
        tick(); #1;
        chk("s1_ptr_E_after_L", 64'(sel[PORT_E*NP +: NP]), 64'h02);
        repeat (4) tick();
        req = '0;

        // N, W, S all toward L
        tick(); clear_gcnt();
        send_pkt(PORT_N, PORT_L, 2, 2);
        send_pkt(PORT_W, PORT_L, 2, 2);
        send_pkt(PORT_S, PORT_L, 2, 2);
        for (int k = 0; k < 9; k++) begin
            tick(); #1;
            chk("s2_grant_L", 64'(grant[PORT_L*NP +: NP]), 64'(s2_pat[k]));
        end
        req = '0;

        // E -> N with a three-cycle downstream stall
        tick(); clear_gcnt(); send_pkt(PORT_E, PORT_N, 5, 5);
        for (int k = 0; k < 8; k++) begin
            tick();
            dcts[PORT_N] = !(k >= 2 && k <= 4);
            #1;
            chk("s3_grant_N_E", 64'(grant[PORT_N*NP + PORT_E]), 64'(s3_pat[k]));
        end
        dcts = '1;
        tick(); #1;
        chk("s3_busy_fall", 64'(busy[PORT_N]), 64'd0);
        chk("s3_grant_cnt", 64'(gcnt[PORT_N][PORT_E]), 64'd5);
        req = '0;

        // Zero length field behaves as a single flit
        tick(); clear_gcnt(); send_pkt(PORT_S, PORT_W, 0, 1);
        tick(); #1;
        chk("s4_grant_W_S", 64'(grant[PORT_W*NP + PORT_S]), 64'd1);
        tick(); #1;
        chk("s4_busy_fall", 64'(busy[PORT_W]), 64'd0);
        chk("s4_grant_cnt", 64'(gcnt[PORT_W][PORT_S]), 64'd1);
        req = '0;

        // Asynchronous reset mid-packet
        tick(); send_pkt(PORT_L, PORT_E, 6, 6);
        tick();
        tick(); #1;
        chk("s5_busy_pre", 64'(busy[PORT_E]), 64'd1);
        rst = 1'b1;
        #1;
        chk("s5_busy_async",  64'(busy),  64'd0);
        chk("s5_grant_async", 64'(grant), 64'd0);
        chk("s5_rd_en_async", 64'(rd_en), 64'd0);
        chk("s5_sel_async",   64'(sel),   64'd0);
        for (int i = 0; i < NP; i++) begin left[i] = 0; first[i] = 1'b0; end
        req = '0;
        drive_inputs();
        tick();
        tick();
        rst = 1'b0;
        tick();
        send_pkt(PORT_L, PORT_E, 1, 1);
        send_pkt(PORT_N, PORT_E, 1, 1);
        tick(); #1;
        chk("s5_L_first", 64'(sel[PORT_E*NP +: NP]), 64'h01);
        repeat (4) tick();
        req = '0;

        // BODY flit at an unowned input is never granted
        tick(); clear_gcnt();
        force_body[PORT_W] = 1'b1;
        left[PORT_W]  = 3;
        first[PORT_W] = 1'b0;
        req[PORT_W*NP + PORT_N] = 1'b1;
        req[PORT_W*NP + PORT_L] = 1'b1;
        drive_inputs();
        for (int k = 0; k < 8; k++) begin
            tick(); #1;
            chk("s6_no_pop_W", 64'(rd_en[PORT_W]), 64'd0);
        end
        tot = 0;
        for (int o = 0; o < NP; o++) tot += gcnt[o][PORT_W];
        chk("s6_no_grant_W", 64'(tot), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
